// File: rtl/gb_mcycle_sequencer.sv
// gb_mcycle_sequencer: T-state/M-cycle timing and strobes for the GameBuddy CPU core.
// Define GB_MEM_WAIT_EN to build the WAIT state that lets mem_wait stretch T2.
module gb_mcycle_sequencer #(
  parameter int MAX_MCYCLES = 6,
  parameter int MCW = 3
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           mc_last,
  input  logic           mc_mem_rd,
  input  logic           mc_mem_wr,
  input  logic [2:0]     mc_addr_sel,
  input  logic           mc_inc_pc,
  input  logic           mc_wr_en,
  input  logic           mc_wr_flags,
  input  logic           mem_wait,
  input  logic           halt_req,
  input  logic           wake,
  output logic [1:0]     t_state,
  output logic [MCW-1:0] m_cycle,
  output logic           m1t1,
  output logic           writeback,
  output logic           rf_wr_en,
  output logic           rf_wr_en_flags,
  output logic           rf_rd_en,
  output logic           drive_addr,
  output logic [2:0]     mem_addr_sel,
  output logic           mem_rd,
  output logic           mem_wr,
  output logic           inc_pc,
  output logic           halted,
  output logic           seq_error
);
  localparam logic [1:0] RUN = 2'd0;
  localparam logic [1:0] HALT = 2'd2;
`ifdef GB_MEM_WAIT_EN
  localparam logic [1:0] WAIT = 2'd1;
`else
  logic unused_mem_wait;
  assign unused_mem_wait = mem_wait;
`endif
  localparam logic [MCW-1:0] LAST_MC = MCW'(MAX_MCYCLES - 1);
  logic [1:0] state, t;
  logic [MCW-1:0] m;
  logic act, m1, t4, t23, mem_cyc;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
      t <= 2'd0;
      m <= '0;
    end else if (state == HALT) begin
      if (wake) state <= RUN;
    end
`ifdef GB_MEM_WAIT_EN
    else if (state == WAIT) begin
      if (!mem_wait) begin
        state <= RUN;
        t <= 2'd2;
      end
    end else if (t == 2'd1 && mem_wait) begin
      state <= WAIT;
    end
`endif
    else begin
      t <= t + 2'd1;
      if (t == 2'd3) begin
        m <= (mc_last || m == LAST_MC) ? '0 : m + 1'b1;
        if (halt_req && mc_last) state <= HALT;
      end
    end
  end
  // WAIT keeps t at T2, so the T2 decodes below hold their values through the stall
  assign act = !rst && state != HALT;
  assign m1 = m == '0;
  assign t4 = t == 2'd3;
  assign t23 = t == 2'd1 || t == 2'd2;
  assign mem_cyc = m1 || mc_mem_rd || mc_mem_wr;
  assign t_state = rst ? 2'd0 : t;
  assign m_cycle = rst ? '0 : m;
  assign m1t1 = act && m1 && t == 2'd0;
  assign writeback = act && t4;
  assign rf_wr_en = writeback && mc_wr_en;
  assign rf_wr_en_flags = writeback && mc_wr_flags;
  assign rf_rd_en = act && (t == 2'd2 || t4);
  assign drive_addr = act && !t4 && mem_cyc;
  assign mem_addr_sel = (act && !m1) ? mc_addr_sel : 3'b000;
  assign mem_rd = act && t23 && (m1 || (mc_mem_rd && !mc_mem_wr));
  assign mem_wr = act && t23 && !m1 && mc_mem_wr;
  assign inc_pc = act && t4 && !m1 && mc_inc_pc;
  assign halted = !rst && state == HALT;
  assign seq_error = writeback && m == LAST_MC && !mc_last;
endmodule

// File: doc/gb_mcycle_sequencer.md
Name: gb_mcycle_sequencer

Overview:
- Generates the T-state/M-cycle timing that drives the 8-bit register file, PC and memory interface of the GameBuddy CPU core.
- Counts T1..T4 within each M-cycle and M1..Mn within each instruction, using per-M-cycle descriptors from the instruction decoder.
- Emits the register-file strobes: m1t1, writeback, wr_en, wr_en_flags, rd_en, drive_addr, mem_addr_sel and inc_pc.
- Also emits memory read/write strobes.
- Handles HALT entry/exit and optional memory wait states.

Parameters:
- MAX_MCYCLES, 6: maximum M-cycles per instruction including M1 fetch; legal range 2..8.
- MCW, 3: width of m_cycle output; must satisfy 2**MCW >= MAX_MCYCLES.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- mc_last  in  1  decoder: current M-cycle is the last of the instruction
- mc_mem_rd  in  1  decoder: current M-cycle (M2+) reads memory
- mc_mem_wr  in  1  decoder: current M-cycle (M2+) writes memory
- mc_addr_sel  in  3  decoder: address source for M2+ (000 PC, 100 BC, 101 DE, 110 HL)
- mc_inc_pc  in  1  decoder: increment PC at T4 of current M2+ cycle
- mc_wr_en  in  1  decoder: write register file at T4
- mc_wr_flags  in  1  decoder: write F at T4
- mem_wait  in  1  memory not ready; stretches T2
- halt_req  in  1  decoder: current instruction is HALT
- wake  in  1  interrupt pending; exits HALT
- t_state  out  2  0=T1, 1=T2, 2=T3, 3=T4
- m_cycle  out  MCW  0=M1 ... MAX_MCYCLES-1
- m1t1  out  1  high during T1 of M1 (PC advance strobe)
- writeback  out  1  high during T4 (register-file clock strobe)
- rf_wr_en  out  1  = mc_wr_en during T4, else 0
- rf_wr_en_flags  out  1  = mc_wr_flags during T4, else 0
- rf_rd_en  out  1  high during T3 and T4
- drive_addr  out  1  high T1..T3 of M1, and T1..T3 of M2+ when mc_mem_rd|mc_mem_wr
- mem_addr_sel  out  3  000 in M1; mc_addr_sel in M2+
- mem_rd  out  1  high T2..T3 of M1, and T2..T3 of M2+ with mc_mem_rd
- mem_wr  out  1  high T2..T3 of M2+ with mc_mem_wr (never in M1)
- inc_pc  out  1  = mc_inc_pc during T4 of M2+, else 0
- halted  out  1  high while in HALT
- seq_error  out  1  one-cycle pulse on M-cycle overrun

Behaviour:
- State machine: RUN, WAIT, HALT.
  - Registers: state, t_state, m_cycle.
  - Outputs are combinational decodes of these registers plus the current mc_* inputs.
  - All outputs are forced 0 in any cycle where rst=1.
- Reset (rst=1 at posedge):
  - state=RUN, t_state=T1, m_cycle=0.
  - First cycle after rst falls is M1/T1, with m1t1=1.
- RUN:
  - t_state advances T1→T2→T3→T4→T1 each clk.
  - At end of T4:
    - if mc_last: m_cycle←0;
    - else m_cycle←m_cycle+1.
  - Overrun: if m_cycle==MAX_MCYCLES-1 and mc_last=0 at T4, then m_cycle←0 and seq_error=1 for that T4 cycle.
- mc_* inputs:
  - Sampled combinationally each cycle and must be stable T1..T4 of an M-cycle.
  - mc_mem_rd and mc_mem_wr both high is illegal: mem_wr wins, mem_rd=0.
- WAIT (only with the optional feature): entered from T2 when mem_wait=1 at posedge.
  - t_state holds T2; drive_addr/mem_rd/mem_wr hold their T2 values.
  - Returns to RUN/T3 on the first posedge with mem_wait=0.
- HALT:
  - Entered at end of T4 when halt_req=1 and mc_last=1.
  - In HALT: t_state=T1, m_cycle=0, halted=1, all strobes 0 (including m1t1).
  - Leaves to RUN on the posedge where wake=1; the next cycle is M1/T1 with m1t1=1.
  - wake=1 in the same T4 that enters HALT: HALT is still entered, for at least one cycle.
- Simultaneous rst with any state: rst wins.
- Minimum instruction length is 4 clks (M1 only). PC does not advance during HALT or WAIT.

Optional Feature:
- Macro: GB_MEM_WAIT_EN.
- Defined: the WAIT state exists and mem_wait stretches T2 as described.
- Undefined: mem_wait is ignored, no WAIT state is built, and every M-cycle is exactly 4 clks.

Test Plan:
- Reset release, mc_last=1 tied (NOP stream) → m1t1 high on clk 0,4,8; writeback on clk 3,7,11; mem_rd on clk 1-2; mem_addr_sel=000.
- 3-M-cycle instruction: mc_last=1 only in M3; M2 mc_mem_rd=1, mc_addr_sel=110, mc_inc_pc=0 → m_cycle sequence 0,1,2,0; drive_addr with sel 110 during M2 clk 4-6; next m1t1 at clk 12.
- mc_last never asserted with MAX_MCYCLES=6 → seq_error pulse at clk 23; m_cycle wraps to 0; m1t1 at clk 24.
- HALT: halt_req=1, mc_last=1 in M1 → halted=1 from clk 4, no m1t1; wake=1 at clk 10 → halted=0 and m1t1=1 at clk 11.
- GB_MEM_WAIT_EN defined, mem_wait=1 for 3 clks starting at M1/T2 → T2 held 4 clks total; mem_rd continuous; writeback at clk 6. Undefined: writeback at clk 3.
- rst asserted mid-M2 at T3 → all outputs 0 that cycle; following cycle is M1/T1 with m1t1=1.
